// File: rtl/ff_test_pkg.sv
// Shared types and constants for the negedge flip-flop test sequencer.
package ff_test_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRIVE = 3'd2,
        CLKLO = 3'd3,
        CHECK = 3'd4,
        FIN   = 3'd5
    } ff_state_e;

    // Feedback taps on bits 7,5,4,3 give the maximal-length 255 sequence.
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_DEFAULT_SEED = 8'h01;
    localparam int         PHASE_W           = 4;

    function automatic logic lfsr_feedback(input logic [7:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], lfsr_feedback(s)};
    endfunction

endpackage

// File: rtl/ff_test_lfsr.sv
// 8-bit Fibonacci LFSR producing the test data pattern; updates on falling cn.
module ff_test_lfsr
    import ff_test_pkg::*;
(
    input  logic       cn,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] state
);

    logic [7:0] lfsr_r;

    // LFSR register: a zero seed would lock up the sequence, so it maps to the default.
    always_ff @(negedge cn) begin
        if (rst) begin
            lfsr_r <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr_r <= (seed == 8'h00) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/ff_test_seq.sv
// Sequencer that clocks pseudo-random data through a negedge flop under test
// and counts Q/QN mismatches; every output is a register updated on falling CN.
module ff_test_seq
    import ff_test_pkg::*;
#(
    parameter int N_VEC = 16,
    parameter int HALF  = 2,
    parameter int ERRW  = 8
) (
    input  logic            CN,
    input  logic            RST,
    input  logic            START,
    input  logic [7:0]      SEED,
    output logic            DUT_CN,
    output logic            DUT_D,
    input  logic            DUT_Q,
    input  logic            DUT_QN,
    output logic            BUSY,
    output logic            DONE,
    output logic [ERRW-1:0] ERR_CNT,
    output logic [7:0]      VEC_CNT
);

    localparam logic [PHASE_W-1:0] PH_ZERO   = {PHASE_W{1'b0}};
    localparam logic [PHASE_W-1:0] PH_ONE    = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PH_RELOAD = PHASE_W'(HALF - 1);
    localparam logic [ERRW-1:0]    ERR_ZERO  = {ERRW{1'b0}};
    localparam logic [ERRW-1:0]    ERR_ONE   = ERRW'(1);
    localparam logic [ERRW-1:0]    ERR_MAX   = {ERRW{1'b1}};
    localparam logic [7:0]         N_VEC_L   = 8'(N_VEC);

    ff_state_e          state_r, state_s;
    logic [PHASE_W-1:0] phase_r, phase_s, phase_hold_s;
    logic               dut_cn_r, dut_cn_s;
    logic               dut_d_r, dut_d_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic [ERRW-1:0]    err_cnt_r, err_cnt_s;
    logic [7:0]         vec_cnt_r, vec_cnt_s, vec_inc_s;
    logic [7:0]         lfsr_s;
    logic               lfsr_load_s, lfsr_adv_s;
    logic               mismatch_s;

    ff_test_lfsr u_lfsr (
        .cn      (CN),
        .rst     (RST),
        .load    (lfsr_load_s),
        .seed    (SEED),
        .advance (lfsr_adv_s),
        .state   (lfsr_s)
    );

    // Next-state, counter and output decode; outputs follow the state being entered.
    always_comb begin
        state_s      = state_r;
        phase_hold_s = phase_r;
        dut_d_s      = dut_d_r;
        err_cnt_s    = err_cnt_r;
        vec_cnt_s    = vec_cnt_r;
        lfsr_load_s  = 1'b0;
        lfsr_adv_s   = 1'b0;
        vec_inc_s    = vec_cnt_r + 8'd1;
        mismatch_s   = (DUT_Q != dut_d_r) || (DUT_QN != ~dut_d_r);

        case (state_r)
            IDLE: begin
                if (START) begin
                    state_s     = LOAD;
                    lfsr_load_s = 1'b1;
                    err_cnt_s   = ERR_ZERO;
                    vec_cnt_s   = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                state_s = DRIVE;
                dut_d_s = lfsr_s[0];
            end
            DRIVE: begin
                if (phase_r == PH_ZERO) begin
                    state_s = CLKLO;
                end else begin
                    phase_hold_s = phase_r - PH_ONE;
                end
            end
            CLKLO: begin
                if (phase_r == PH_ZERO) begin
                    state_s = CHECK;
                end else begin
                    phase_hold_s = phase_r - PH_ONE;
                end
            end
            CHECK: begin
                vec_cnt_s  = vec_inc_s;
                lfsr_adv_s = 1'b1;
                if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
                    err_cnt_s = err_cnt_r + ERR_ONE;
                end else begin
                    err_cnt_s = err_cnt_r;
                end
                // The next vector's bit is the feedback bit the LFSR shifts in this edge.
                if (vec_inc_s == N_VEC_L) begin
                    state_s = FIN;
                end else begin
                    state_s = DRIVE;
                    dut_d_s = lfsr_feedback(lfsr_s);
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        phase_s  = (state_s != state_r) ? PH_RELOAD : phase_hold_s;
        dut_cn_s = ~((state_s == CLKLO) || (state_s == CHECK));
        busy_s   = (state_s != IDLE);
        done_s   = (state_s == FIN);
    end

    // State, phase counter and output registers.
    always_ff @(negedge CN) begin
        if (RST) begin
            state_r   <= IDLE;
            phase_r   <= PH_ZERO;
            dut_cn_r  <= 1'b1;
            dut_d_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_cnt_r <= ERR_ZERO;
            vec_cnt_r <= 8'd0;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            dut_cn_r  <= dut_cn_s;
            dut_d_r   <= dut_d_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            err_cnt_r <= err_cnt_s;
            vec_cnt_r <= vec_cnt_s;
        end
    end

    assign DUT_CN  = dut_cn_r;
    assign DUT_D   = dut_d_r;
    assign BUSY    = busy_r;
    assign DONE    = done_r;
    assign ERR_CNT = err_cnt_r;
    assign VEC_CNT = vec_cnt_r;

endmodule

// File: tb/tb_ff_test_seq.sv
// Directed bench for ff_test_seq: a cycle-timeline model checks instance A every
// cycle; instances B (stuck Q) and C (QN tied to Q, 2-bit counter) are checked at run end.
module tb_ff_test_seq;

    localparam int NA = 16;
    localparam int HA = 2;
    localparam int NB = 8;
    localparam int NC = 10;
    localparam int EWC = 2;

    logic       cn;
    logic       rst;
    logic       start_a, start_b, start_c;
    logic [7:0] seed_a, seed_b, seed_c;

    logic       a_dut_cn, a_dut_d, a_q, a_qn, a_busy, a_done;
    logic [7:0] a_err, a_vec;
    logic       b_dut_cn, b_dut_d, b_q, b_qn, b_busy, b_done;
    logic [7:0] b_err, b_vec;
    logic       c_dut_cn, c_dut_d, c_q, c_qn, c_busy, c_done;
    logic [EWC-1:0] c_err;
    logic [7:0] c_vec;

    bit   mode_a = 1'b0;
    logic fq_a = 1'b0;
    logic fq_c = 1'b0;
    bit   cap_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;
    int b_busy_cyc = 0, c_busy_cyc = 0;

    ff_test_seq #(.N_VEC(NA), .HALF(HA), .ERRW(8)) dut_a (
        .CN(cn), .RST(rst), .START(start_a), .SEED(seed_a),
        .DUT_CN(a_dut_cn), .DUT_D(a_dut_d), .DUT_Q(a_q), .DUT_QN(a_qn),
        .BUSY(a_busy), .DONE(a_done), .ERR_CNT(a_err), .VEC_CNT(a_vec)
    );

    ff_test_seq #(.N_VEC(NB), .HALF(HA), .ERRW(8)) dut_b (
        .CN(cn), .RST(rst), .START(start_b), .SEED(seed_b),
        .DUT_CN(b_dut_cn), .DUT_D(b_dut_d), .DUT_Q(b_q), .DUT_QN(b_qn),
        .BUSY(b_busy), .DONE(b_done), .ERR_CNT(b_err), .VEC_CNT(b_vec)
    );

    ff_test_seq #(.N_VEC(NC), .HALF(HA), .ERRW(EWC)) dut_c (
        .CN(cn), .RST(rst), .START(start_c), .SEED(seed_c),
        .DUT_CN(c_dut_cn), .DUT_D(c_dut_d), .DUT_Q(c_q), .DUT_QN(c_qn),
        .BUSY(c_busy), .DONE(c_done), .ERR_CNT(c_err), .VEC_CNT(c_vec)
    );

    initial begin
        cn = 1'b1;
        forever #5 cn = ~cn;
    end

    // Flops under test: A is a negedge D-flop (optionally stuck at 0), B stuck at 0, C has QN tied to Q.
    always @(negedge a_dut_cn) fq_a <= a_dut_d;
    always @(negedge a_dut_cn) cap_q.push_back(a_dut_d);
    always @(negedge c_dut_cn) fq_c <= c_dut_d;
    assign a_q  = mode_a ? 1'b0 : fq_a;
    assign a_qn = ~a_q;
    assign b_q  = 1'b0;
    assign b_qn = ~b_q;
    assign c_q  = fq_c;
    assign c_qn = fq_c;

    always @(posedge cn) begin
        if (a_done) a_done_cnt <= a_done_cnt + 1;
        if (b_done) b_done_cnt <= b_done_cnt + 1;
        if (c_done) c_done_cnt <= c_done_cnt + 1;
        if (b_busy) b_busy_cyc <= b_busy_cyc + 1;
        if (c_busy) c_busy_cyc <= c_busy_cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return ((v << 1) & 8'hFE) | {7'd0, fb};
    endfunction

    function automatic logic [15:0] dseq16(input logic [7:0] seed);
        logic [7:0]  v;
        logic [15:0] r;
        v = (seed == 8'h00) ? 8'h01 : seed;
        r = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            r[k] = v[0];
            v = model_next(v);
        end
        return r;
    endfunction

    function automatic logic [15:0] pack16(input bit q[$]);
        logic [15:0] r;
        r = 16'h0000;
        for (int k = 0; k < 16 && k < q.size(); k++) r[k] = q[k];
        return r;
    endfunction

    // Timeline model for instance A
    bit m_d[NA];
    bit m_mm[NA];
    bit m_run = 1'b0;
    int m_off = 0;
    int m_vec = 0;
    int m_err = 0;
    int m_last_d = 0;

    task automatic model_load(input logic [7:0] seed, input bit stuck);
        logic [7:0] v;
        v = (seed == 8'h00) ? 8'h01 : seed;
        for (int k = 0; k < NA; k++) begin
            m_d[k]  = v[0];
            m_mm[k] = stuck & v[0];
            v = model_next(v);
        end
    endtask

    function automatic int err_upto(input int j);
        int s;
        s = 0;
        for (int k = 0; k < j; k++) s += int'(m_mm[k]);
        return (s > 255) ? 255 : s;
    endfunction

    initial begin : compare_proc
        int per, len, j, p;
        int e_busy, e_done, e_cn, e_d, e_vec, e_err;
        per = 2 * HA + 1;
        len = 1 + NA * per + 1;
        forever begin
            @(negedge cn);
            if (rst) begin
                m_run = 1'b0; m_off = 0; m_vec = 0; m_err = 0; m_last_d = 0;
            end else if (m_run) begin
                if (m_off == len - 1) begin
                    m_run = 1'b0;
                    m_vec = NA;
                    m_err = err_upto(NA);
                    m_last_d = int'(m_d[NA-1]);
                end else begin
                    m_off++;
                end
            end else if (start_a) begin
                m_run = 1'b1;
                m_off = 0;
                model_load(seed_a, mode_a);
            end
            @(posedge cn);
            if (!m_run) begin
                e_busy = 0; e_done = 0; e_cn = 1; e_d = m_last_d; e_vec = m_vec; e_err = m_err;
            end else if (m_off == 0) begin
                e_busy = 1; e_done = 0; e_cn = 1; e_d = m_last_d; e_vec = 0; e_err = 0;
            end else if (m_off == len - 1) begin
                e_busy = 1; e_done = 1; e_cn = 1; e_d = int'(m_d[NA-1]); e_vec = NA; e_err = err_upto(NA);
            end else begin
                j = (m_off - 1) / per;
                p = (m_off - 1) % per;
                e_busy = 1; e_done = 0; e_cn = (p < HA) ? 1 : 0;
                e_d = int'(m_d[j]); e_vec = j; e_err = err_upto(j);
            end
            check("cyc_busy", int'(a_busy), e_busy);
            check("cyc_done", int'(a_done), e_done);
            check("cyc_dut_cn", int'(a_dut_cn), e_cn);
            check("cyc_dut_d", int'(a_dut_d), e_d);
            check("cyc_vec_cnt", int'(a_vec), e_vec);
            check("cyc_err_cnt", int'(a_err), e_err);
        end
    end

    task automatic run_a(input logic [7:0] seed, input bit stuck, input int pulse_vec,
                         input bit with_bc, output int len, output int load_err);
        bit fin;
        bit pulsed;
        @(posedge cn);
        seed_a = seed;
        mode_a = stuck;
        cap_q.delete();
        start_a = 1'b1;
        if (with_bc) begin
            start_b = 1'b1;
            start_c = 1'b1;
        end
        @(posedge cn);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        load_err = int'(a_err);
        len = 0; fin = 1'b0; pulsed = 1'b0;
        for (int t = 0; t < 2000 && !fin; t++) begin
            if (a_busy) len++;
            if (a_done) begin
                fin = 1'b1;
            end else begin
                if (pulse_vec >= 0 && !pulsed && int'(a_vec) == pulse_vec) begin
                    start_a = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start_a = 1'b0;
                end
                @(posedge cn);
            end
        end
        start_a = 1'b0;
        check("run_done_seen", int'(fin), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin : main
        int len, lerr, done0;
        bit found;
        logic [15:0] s01;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        seed_a = 8'h00; seed_b = 8'h01; seed_c = 8'h5A;
        repeat (3) @(posedge cn);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_dut_cn", int'(a_dut_cn), 1);
        check("rst_dut_d", int'(a_dut_d), 0);
        check("rst_err", int'(a_err), 0);
        check("rst_vec", int'(a_vec), 0);
        check("rst_b_busy", int'(b_busy), 0);
        check("rst_c_busy", int'(c_busy), 0);
        rst = 1'b0;

        // Hand-derived LFSR bits from seed 01: 01,02,04,08,11,23,47,8E,1C,38,71,E2,C4,89,12,25
        s01 = dseq16(8'h01);
        check("model_seq_01", int'(s01), 32'hA471);
        check("model_seq_00", int'(dseq16(8'h00)), 32'hA471);
        check("model_ones8", $countones(s01[7:0]), 4);
        check("model_ones16", $countones(s01), 7);

        // Nominal run on A, with B and C running alongside
        run_a(8'hA5, 1'b0, -1, 1'b1, len, lerr);
        check("nom_len", len, 82);
        check("nom_err", int'(a_err), 0);
        check("nom_vec", int'(a_vec), 16);
        check("nom_caps", cap_q.size(), NA);
        check("nom_dseq", int'(pack16(cap_q)), int'(dseq16(8'hA5)));
        check("stuck_b_err", int'(b_err), 4);
        check("stuck_b_err_model", int'(b_err), $countones(s01[7:0]));
        check("stuck_b_vec", int'(b_vec), NB);
        check("stuck_b_len", b_busy_cyc, 1 + NB * (2 * HA + 1) + 1);
        check("stuck_b_dones", b_done_cnt, 1);
        check("sat_c_err", int'(c_err), 3);
        check("sat_c_vec", int'(c_vec), NC);
        check("sat_c_len", c_busy_cyc, 1 + NC * (2 * HA + 1) + 1);
        check("sat_c_dones", c_done_cnt, 1);

        // Stuck-at-0 Q on A, seed 01
        run_a(8'h01, 1'b1, -1, 1'b0, len, lerr);
        check("stuck_a_err", int'(a_err), 7);
        check("stuck_a_dseq", int'(pack16(cap_q)), 32'hA471);

        // Zero seed behaves as seed 01
        run_a(8'h00, 1'b0, -1, 1'b0, len, lerr);
        check("zero_dseq", int'(pack16(cap_q)), 32'hA471);
        check("zero_err", int'(a_err), 0);

        // Reset during CLKLO of vector 5
        @(posedge cn);
        seed_a = 8'h01; mode_a = 1'b1; start_a = 1'b1;
        @(posedge cn);
        start_a = 1'b0;
        done0 = a_done_cnt;
        found = 1'b0;
        for (int t = 0; t < 500 && !found; t++) begin
            if (a_busy && a_vec == 8'd4 && a_dut_cn == 1'b0) found = 1'b1;
            else @(posedge cn);
        end
        check("rmid_reached", int'(found), 1);
        check("rmid_err_before", int'(a_err), 1);
        rst = 1'b1;
        @(posedge cn);
        check("rmid_busy", int'(a_busy), 0);
        check("rmid_dut_cn", int'(a_dut_cn), 1);
        check("rmid_dut_d", int'(a_dut_d), 0);
        check("rmid_err", int'(a_err), 0);
        check("rmid_vec", int'(a_vec), 0);
        rst = 1'b0;
        repeat (6) @(posedge cn);
        check("rmid_no_done", a_done_cnt - done0, 0);
        check("rmid_idle", int'(a_busy), 0);

        // START pulsed while busy, then back-to-back START after DONE
        run_a(8'h01, 1'b1, 2, 1'b0, len, lerr);
        check("busy_start_len", len, 82);
        check("busy_start_err", int'(a_err), 7);
        check("busy_start_vec", int'(a_vec), 16);
        run_a(8'hA5, 1'b0, -1, 1'b0, len, lerr);
        check("b2b_load_err", lerr, 0);
        check("b2b_len", len, 82);
        check("b2b_err", int'(a_err), 0);
        check("b2b_vec", int'(a_vec), 16);

        repeat (3) @(posedge cn);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ff_test_seq.md
FF_TEST_SEQ -- requirements
Module: ff_test_seq

Interface
REQ-001 The block SHALL have parameter N_VEC, default 16, meaning vectors per run (legal 1..255).
REQ-002 The block SHALL have parameter HALF, default 2, meaning CN cycles per DUT clock phase (legal 1..15).
REQ-003 The block SHALL have parameter ERRW, default 8, meaning error counter width.
REQ-004 The block SHALL have port CN, input, 1 bit: the single clock; all state updates on its falling edge.
REQ-005 The block SHALL have port RST, input, 1 bit: reset, synchronous, active-high, sampled on falling CN.
REQ-006 The block SHALL have port START, input, 1 bit: begin run when idle.
REQ-007 The block SHALL have port SEED, input, 8 bits: LFSR seed captured at start.
REQ-008 The block SHALL have port DUT_CN, output, 1 bit: clock to the flop under test; the DUT captures on its falling edge.
REQ-009 The block SHALL have port DUT_D, output, 1 bit: data to the flop under test.
REQ-010 The block SHALL have port DUT_Q, input, 1 bit: DUT true output.
REQ-011 The block SHALL have port DUT_QN, input, 1 bit: DUT complement output.
REQ-012 The block SHALL have port BUSY, output, 1 bit: run in progress.
REQ-013 The block SHALL have port DONE, output, 1 bit: one-cycle end-of-run pulse.
REQ-014 The block SHALL have port ERR_CNT, output, ERRW bits: mismatches in the last or current run.
REQ-015 The block SHALL have port VEC_CNT, output, 8 bits: vectors checked so far.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRIVE, CLKLO, CHECK and FIN.
REQ-017 IDLE -> LOAD SHALL occur when START=1; START while BUSY=1 SHALL be ignored.
REQ-018 LOAD (1 cycle) SHALL do the following:
- lfsr<=SEED, except SEED=0 loads 8'h01;
- ERR_CNT<=0 and VEC_CNT<=0;
- go to DRIVE.
REQ-019 DRIVE SHALL last HALF cycles, with DUT_CN=1 and DUT_D=lfsr[0] (registered, stable for the whole state), then go to CLKLO.
REQ-020 CLKLO SHALL last HALF cycles with DUT_CN=0; DUT_D SHALL stay unchanged, giving HALF cycles of setup and hold around the DUT falling edge.
REQ-021 CHECK (1 cycle, DUT_CN=0) SHALL proceed as follows:
- mismatch = (DUT_Q != exp) | (DUT_QN != ~exp), where exp is the DUT_D value driven in the preceding DRIVE;
- on mismatch, ERR_CNT SHALL increment, saturating at 2^ERRW-1;
- VEC_CNT SHALL increment;
- lfsr SHALL advance;
- go to FIN if the new VEC_CNT equals N_VEC, else to DRIVE.
REQ-022 The LFSR advance SHALL be lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}, which is maximal length with period 255.
REQ-023 FIN (1 cycle) SHALL drive DUT_CN=1 and DONE=1, then go to IDLE.
REQ-024 BUSY SHALL be 1 in every state except IDLE.
REQ-025 ERR_CNT and VEC_CNT SHALL hold their values in IDLE until the next LOAD.
REQ-026 Run length SHALL be exactly 1 + N_VEC*(2*HALF+1) + 1 cycles from the cycle START is sampled to the DONE cycle inclusive.
REQ-027 The phase counter SHALL be 4 bits, reload to HALF-1 on each state entry, and count down to 0.

Reset
REQ-028 On RST=1 at any falling CN the block SHALL go to IDLE with the following values:
- DUT_CN=1 and DUT_D=0;
- BUSY=0 and DONE=0;
- ERR_CNT=0 and VEC_CNT=0;
- lfsr=8'h01 and phase counter=0.
REQ-029 RST mid-run SHALL abort without asserting DONE; RST SHALL take priority over START.

Structure
REQ-030 A shared package ff_test_pkg SHALL hold the following:
- the state enum;
- the LFSR tap constant;
- the default seed 8'h01;
- the phase counter width 4.
REQ-031 The LFSR SHALL be one sub-module, ff_test_lfsr, with ports for clock, reset, load, seed, advance and state.
REQ-032 All outputs SHALL be registered; there SHALL be no combinational path from DUT_Q/DUT_QN to any output.

Verification
REQ-033 The bench SHALL cover the following directed scenarios:
- Nominal: N_VEC=16, HALF=2, SEED=8'hA5, DUT is the library negedge D-flop model. Required: DONE after 1+16*5+1=82 cycles, ERR_CNT=0, VEC_CNT=16.
- Stuck fault: DUT_Q tied 0, DUT_QN=~DUT_Q, SEED=8'h01, N_VEC=8. Required: ERR_CNT equals the count of ones in the first 8 lfsr[0] values.
- Zero seed: SEED=0. Required: DUT_D sequence identical to the SEED=8'h01 run.
- Reset mid-run: RST=1 during CLKLO of vector 5. Required: next cycle BUSY=0, DUT_CN=1, DUT_D=0, counters 0, no DONE pulse.
- START while busy: START pulsed at vector 3. Required: run length and counts unchanged; back-to-back START in the cycle after DONE starts a new run with ERR_CNT cleared.
- Saturation: ERRW=2, DUT_QN tied to DUT_Q, N_VEC=10. Required: ERR_CNT=3.
